// File: rtl/pixel_array_pkg.sv
// Shared types, register map and helpers for the pixel array sequencer.
// Holds the FSM states, word offsets, bit indices and channel search.
package pixel_array_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOC,
        ST_ADJ,
        ST_SH,
        ST_NEXT
    } pa_state_e;

    localparam logic [2:0] W_CTRL    = 3'd0;
    localparam logic [2:0] W_CHAN_EN = 3'd1;
    localparam logic [2:0] W_LOC_MAX = 3'd2;
    localparam logic [2:0] W_ADJ_MAX = 3'd3;
    localparam logic [2:0] W_STATUS  = 3'd4;

    localparam int C_START  = 0;
    localparam int C_MODE   = 1;
    localparam int C_CONT   = 2;
    localparam int C_SEL    = 3;
    localparam int C_IRQ_EN = 4;
    localparam int C_ABORT  = 5;

    localparam int S_BUSY  = 0;
    localparam int S_KDONE = 1;
    localparam int S_CH    = 4;
    localparam int S_DONE  = 8;

    // Returns {found, index} of the lowest set mask bit at or above from.
    function automatic logic [4:0] find_en(
        input logic [15:0] mask,
        input logic [4:0]  from
    );
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// Phase duration counter shared by the LOC and ADJ phases.
// Cleared on every phase entry; flags the cycle where the count hits max.
module pixel_phase_timer #(
    parameter int TW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [TW-1:0] i_max,
    output logic          o_at_max
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_at_max = (r_cnt == i_max);

endmodule

// File: rtl/pixel_array_seq.sv
// Wishbone-controlled sequencer driving N_PIX pixel channels through
// local-integrate, adjust and sample/hold phases in scan or parallel mode.
module pixel_array_seq
    import pixel_array_pkg::*;
#(
    parameter int         N_PIX     = 4,
    parameter int         TW        = 10,
    parameter logic [3:0] ADDR_BASE = 4'h3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             pxl_start_ext,
    output logic [N_PIX-1:0] pxl_loc_en,
    output logic [N_PIX-1:0] pxl_adj_en,
    output logic [N_PIX-1:0] pxl_sh,
    output logic             pxl_busy,
    output logic             kernel_done_o,
    output logic             irq
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_mode, r_cont, r_sel, r_irq_en;
    logic             r_start, r_abort;
    logic [N_PIX-1:0] r_chan_en;
    logic [TW-1:0]    r_loc_max, r_adj_max;
    logic             r_sticky, r_irq;
    logic             r_ext_s1, r_ext_s2, r_ext_s3;
    pa_state_e        r_state;
    logic [3:0]       r_ch;
    logic [N_PIX-1:0] r_done, r_sh_en;
    logic [TW-1:0]    r_sh_loc, r_sh_adj;
    logic             r_sh_mode;

    logic             w_valid, w_acc, w_wr;
    logic [2:0]       w_word;
    logic             w_wr_ctrl, w_wr_en, w_wr_loc, w_wr_adj, w_wr_stat;
    logic [31:0]      w_bm, w_rdata, w_status;
    logic             w_busy, w_start, w_at_max;
    logic [4:0]       w_first, w_after;
    logic             w_more, w_last, w_kend;
    logic             w_accept, w_reload, w_load;
    logic [N_PIX-1:0] w_act;
    pa_state_e        w_nxt;
    logic             w_unused;

    assign w_valid   = wbs_cyc_i & wbs_stb_i
                     & (wbs_adr_i[31:28] == ADDR_BASE);
    assign w_acc     = w_valid & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_word    = wbs_adr_i[4:2];
    assign w_wr_ctrl = w_wr & (w_word == W_CTRL) & wbs_sel_i[0];
    assign w_wr_en   = w_wr & (w_word == W_CHAN_EN);
    assign w_wr_loc  = w_wr & (w_word == W_LOC_MAX);
    assign w_wr_adj  = w_wr & (w_word == W_ADJ_MAX);
    assign w_wr_stat = w_wr & (w_word == W_STATUS) & wbs_sel_i[0];
    assign w_bm      = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_unused  = ^{wbs_adr_i[27:5], wbs_adr_i[1:0],
                         wbs_dat_i, w_bm};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
            r_mode    <= 1'b0;
            r_cont    <= 1'b0;
            r_sel     <= 1'b0;
            r_irq_en  <= 1'b0;
            r_chan_en <= '1;
            r_loc_max <= TW'(8);
            r_adj_max <= TW'(8);
        end else begin
            r_start <= w_wr_ctrl & wbs_dat_i[C_START];
            r_abort <= w_wr_ctrl & wbs_dat_i[C_ABORT];
            if (w_wr_ctrl) begin
                r_mode   <= wbs_dat_i[C_MODE];
                r_cont   <= wbs_dat_i[C_CONT];
                r_sel    <= wbs_dat_i[C_SEL];
                r_irq_en <= wbs_dat_i[C_IRQ_EN];
            end
            if (w_wr_en) begin
                r_chan_en <= (r_chan_en & ~w_bm[N_PIX-1:0])
                           | (wbs_dat_i[N_PIX-1:0] & w_bm[N_PIX-1:0]);
            end
            if (w_wr_loc) begin
                r_loc_max <= (r_loc_max & ~w_bm[TW-1:0])
                           | (wbs_dat_i[TW-1:0] & w_bm[TW-1:0]);
            end
            if (w_wr_adj) begin
                r_adj_max <= (r_adj_max & ~w_bm[TW-1:0])
                           | (wbs_dat_i[TW-1:0] & w_bm[TW-1:0]);
            end
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[S_BUSY]      = w_busy;
        w_status[S_KDONE]     = r_sticky;
        w_status[S_CH +: 4]   = r_ch;
        w_status[S_DONE +: N_PIX] = r_done;
        w_rdata               = '0;
        case (w_word)
            W_CTRL: begin
                w_rdata[C_MODE]   = r_mode;
                w_rdata[C_CONT]   = r_cont;
                w_rdata[C_SEL]    = r_sel;
                w_rdata[C_IRQ_EN] = r_irq_en;
            end
            W_CHAN_EN: w_rdata[N_PIX-1:0] = r_chan_en;
            W_LOC_MAX: w_rdata[TW-1:0]    = r_loc_max;
            W_ADJ_MAX: w_rdata[TW-1:0]    = r_adj_max;
            W_STATUS:  w_rdata            = w_status;
            default:   w_rdata            = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
            r_ext_s3 <= 1'b0;
            r_sticky <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack    <= w_acc;
            if (w_acc) begin
                r_dat <= w_rdata;
            end
            r_ext_s1 <= pxl_start_ext;
            r_ext_s2 <= r_ext_s1;
            r_ext_s3 <= r_ext_s2;
            if (w_kend) begin
                r_sticky <= 1'b1;
            end else if (w_wr_stat & wbs_dat_i[S_KDONE]) begin
                r_sticky <= 1'b0;
            end
            r_irq <= r_sticky & r_irq_en;
        end
    end

    assign w_busy   = (r_state != ST_IDLE);
    assign w_start  = r_sel ? (r_ext_s2 & ~r_ext_s3) : r_start;
    assign w_first  = find_en(16'(r_chan_en), 5'd0);
    assign w_after  = find_en(16'(r_sh_en), {1'b0, r_ch} + 5'd1);
    assign w_more   = ~r_sh_mode & w_after[4];
    assign w_last   = (r_state == ST_NEXT) & ~w_more;
    assign w_kend   = w_last & ~r_abort;
    assign w_accept = (r_state == ST_IDLE) & w_start
                    & w_first[4] & ~r_abort;
    // Continuous reload re-latches live settings for the next kernel.
    assign w_reload = w_kend & r_cont & w_first[4];
    assign w_load   = w_accept | w_reload;

    always_comb begin
        w_act = '0;
        for (int i = 0; i < N_PIX; i++) begin
            w_act[i] = r_sh_mode ? r_sh_en[i] : (r_ch == 4'(i));
        end
    end

    always_comb begin
        w_nxt      = r_state;
        pxl_loc_en = '0;
        pxl_adj_en = '0;
        pxl_sh     = '0;
        if (r_abort) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_accept) w_nxt = ST_LOC;
                ST_LOC:  if (w_at_max) w_nxt = ST_ADJ;
                ST_ADJ:  if (w_at_max) w_nxt = ST_SH;
                ST_SH:   w_nxt = ST_NEXT;
                ST_NEXT: w_nxt = (w_more | w_reload) ? ST_LOC : ST_IDLE;
                default: w_nxt = ST_IDLE;
            endcase
        end
        unique case (r_state)
            ST_LOC:  pxl_loc_en = w_act;
            ST_ADJ:  pxl_adj_en = w_act;
            ST_SH:   pxl_sh     = w_act;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_done    <= '0;
            r_sh_en   <= '0;
            r_sh_loc  <= '0;
            r_sh_adj  <= '0;
            r_sh_mode <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_load) begin
                r_sh_en   <= r_chan_en;
                r_sh_loc  <= r_loc_max;
                r_sh_adj  <= r_adj_max;
                r_sh_mode <= r_mode;
                r_done    <= '0;
                r_ch      <= w_first[3:0];
            end else if ((r_state == ST_NEXT) && !r_abort) begin
                r_done <= r_done | w_act;
                if (w_more) begin
                    r_ch <= w_after[3:0];
                end
            end
        end
    end

    pixel_phase_timer #(.TW(TW)) u_timer (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clr    (w_nxt != r_state),
        .i_en     ((r_state == ST_LOC) | (r_state == ST_ADJ)),
        .i_max    ((r_state == ST_ADJ) ? r_sh_adj : r_sh_loc),
        .o_at_max (w_at_max)
    );

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign pxl_busy      = w_busy;
    assign kernel_done_o = w_kend;
    assign irq           = r_irq;

endmodule

// File: tb/tb_pixel_array_seq.sv
// Directed bench for pixel_array_seq: register map, scan/parallel
// timing, abort, external start and async reset.
module tb_pixel_array_seq;

    logic        clk;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack;
    logic [31:0] dat_o;
    logic        ext;
    logic [3:0]  loc_en, adj_en, sh;
    logic        busy, kdone, irq;

    logic [13:0] obs;
    logic [31:0] q;
    int          n_chk, n_pass;
    int          na;
    logic        kd;

    pixel_array_seq dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_o),
        .pxl_start_ext (ext),
        .pxl_loc_en    (loc_en),
        .pxl_adj_en    (adj_en),
        .pxl_sh        (sh),
        .pxl_busy      (busy),
        .kernel_done_o (kdone),
        .irq           (irq)
    );

    assign obs = {loc_en, adj_en, sh, kdone, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [2:0] word,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd);
        logic got;
        cyc = 1'b1;
        stb = 1'b1;
        we  = w;
        adr = {4'h3, 23'd0, word, 2'b00};
        dat = d;
        sel = s;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        rd  = dat_o;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        if (!got) check("ack timeout", 32'(got), 32'd1);
    endtask

    task automatic wr(input logic [2:0] word, input logic [31:0] d);
        logic [31:0] unused_rd;
        xfer(1'b1, word, d, 4'hF, unused_rd);
    endtask

    task automatic rd(input logic [2:0] word, output logic [31:0] v);
        xfer(1'b0, word, 32'd0, 4'hF, v);
    endtask

    // Expected {loc,adj,sh,kdone,busy} at cycle c after LOC entry.
    function automatic logic [13:0] exp_vec(
        int c, int L, int A,
        logic [3:0] m0, logic [3:0] m1, int np
    );
        int          p, k, ph;
        logic [3:0]  m;
        logic [13:0] v;
        p = L + A + 4;
        k = (c - 1) / p;
        ph = (c - 1) % p;
        v = '0;
        if (k < np) begin
            m = (k == 0) ? m0 : m1;
            v[0] = 1'b1;
            if (ph <= L) v[13:10] = m;
            else if (ph <= L + A + 1) v[9:6] = m;
            else if (ph == L + A + 2) v[5:2] = m;
            else v[1] = (k == np - 1);
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        sel = 4'h0;
        adr = '0;
        dat = '0;
        ext = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ack", 32'(ack), 32'd0);
        check("rst dat", dat_o, 32'd0);
        check("rst outs", {obs, irq}, 32'd0);
        rst = 1'b0;
        step();

        rd(3'd0, q); check("CTRL rst", q, 32'h0);
        rd(3'd1, q); check("CHAN_EN rst", q, 32'hF);
        rd(3'd2, q); check("LOC_MAX rst", q, 32'd8);
        rd(3'd3, q); check("ADJ_MAX rst", q, 32'd8);
        rd(3'd4, q); check("STATUS rst", q, 32'h0);
        rd(3'd5, q); check("unmapped", q, 32'h0);
        xfer(1'b1, 3'd1, 32'h0, 4'b0000, q);
        rd(3'd1, q); check("sel0 write", q, 32'hF);
        xfer(1'b1, 3'd2, 32'h3FF, 4'b0001, q);
        rd(3'd2, q); check("byte lane", q, 32'h0FF);

        cyc = 1'b1;
        stb = 1'b1;
        adr = {4'h2, 28'h0};
        na = 0;
        repeat (3) begin
            step();
            na += int'(ack);
        end
        cyc = 1'b0;
        stb = 1'b0;
        check("other base ack", 32'(na), 32'd0);

        wr(3'd1, 32'h0);
        wr(3'd0, 32'h01);
        step();
        step();
        check("start chan0", 32'(busy), 32'd0);

        // scan: ch0 then ch2, loc 2, adj 3
        wr(3'd1, 32'h5);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h10);
        wr(3'd0, 32'h11);
        for (int c = 1; c <= 20; c++) begin
            step();
            check($sformatf("scan c%0d", c), 32'(obs),
                  32'(exp_vec(c, 2, 3, 4'h1, 4'h4, 2)));
            if (c == 19) check("scan irq c19", 32'(irq), 32'd0);
            if (c == 20) check("scan irq c20", 32'(irq), 32'd1);
        end
        rd(3'd4, q); check("scan STATUS", q, 32'h522);

        // parallel, all four channels, loc 0 adj 0
        wr(3'd4, 32'h2);
        step();
        check("w1c irq", 32'(irq), 32'd0);
        wr(3'd1, 32'hF);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h13);
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("par c%0d", c), 32'(obs),
                  32'(exp_vec(c, 0, 0, 4'hF, 4'h0, 1)));
        end
        rd(3'd4, q); check("par STATUS", q, 32'hF02);
        check("par irq", 32'(irq), 32'd1);
        wr(3'd4, 32'h2);
        step();
        check("par irq clr", 32'(irq), 32'd0);
        rd(3'd4, q); check("par STATUS clr", q, 32'hF00);

        // continuous scan, abort mid-ADJ of ch1
        wr(3'd1, 32'h3);
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd4);
        wr(3'd0, 32'h05);
        kd = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            step();
            kd |= kdone;
            check($sformatf("cont c%0d", c), 32'(obs),
                  32'(exp_vec(c, 1, 4, 4'h1, 4'h2, 2)));
        end
        wr(3'd0, 32'h25);
        kd |= kdone;
        check("abort c14", 32'(obs), 32'h0081);
        step();
        check("abort c15", 32'(obs), 32'h0);
        repeat (4) begin
            step();
            kd |= kdone | busy;
        end
        check("abort no kdone", 32'(kd), 32'd0);
        rd(3'd4, q); check("abort STATUS", q, 32'h110);
        wr(3'd0, 32'h21);
        step();
        step();
        check("abort beats start", 32'(busy), 32'd0);

        // external start, LOC_MAX change mid-run
        wr(3'd1, 32'h1);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h08);
        ext = 1'b1;
        step();
        check("ext edge1", 32'(busy), 32'd0);
        step();
        check("ext edge2", 32'(busy), 32'd0);
        step();
        check("ext c1", 32'(obs), 32'(exp_vec(1, 3, 0, 4'h1, 4'h0, 1)));
        ext = 1'b0;
        step();
        check("ext c2", 32'(obs), 32'(exp_vec(2, 3, 0, 4'h1, 4'h0, 1)));
        ext = 1'b1;
        wr(3'd2, 32'd0);
        ext = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            check($sformatf("ext c%0d", c), 32'(obs),
                  32'(exp_vec(c, 3, 0, 4'h1, 4'h0, 1)));
            step();
        end
        rd(3'd2, q); check("ext LOC_MAX", q, 32'd0);
        ext = 1'b1;
        step();
        step();
        step();
        ext = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("ext2 c%0d", c), 32'(obs),
                  32'(exp_vec(c, 0, 0, 4'h1, 4'h0, 1)));
            step();
        end

        // asynchronous reset mid-run
        wr(3'd2, 32'd20);
        wr(3'd0, 32'h01);
        step();
        step();
        check("pre-rst busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid-run", {obs, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        rd(3'd2, q); check("LOC_MAX after rst", q, 32'd8);
        rd(3'd0, q); check("CTRL after rst", q, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
